// File: rtl/elevator_scan_ctrl.sv
// LOOK-scheduled elevator controller: latches floor calls, tracks the car floor, sequences move/door timers.
// Calls show in floor_req one cycle after req_set; availability flags are combinational from registered state.
module elevator_scan_ctrl #(
  parameter int N_FLOORS    = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] req_set,
  output logic [FLOOR_W-1:0]  floor,
  output logic [N_FLOORS-1:0] floor_req,
  output logic                moving_up,
  output logic                moving_down,
  output logic                door_open,
  output logic                up_available,
  output logic                down_available
);

  localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DOOR} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  state_t              r_state, w_state_nxt;
  dir_t                r_dir, w_dir_nxt;
  logic [FLOOR_W-1:0]  r_floor, w_floor_nxt;
  logic [N_FLOORS-1:0] r_req, w_req_nxt;
  logic [CNT_W-1:0]    r_mcnt, w_mcnt_nxt;
  logic [CNT_W-1:0]    r_dcnt, w_dcnt_nxt;

  logic [FLOOR_W-1:0]  w_floor_up, w_floor_dn;
  logic [N_FLOORS-1:0] w_oh_cur, w_oh_up, w_oh_dn;
  logic [N_FLOORS-1:0] w_req_in, w_clr_mask;
  logic                w_up_av, w_dn_av, w_above_up, w_below_dn;

  assign w_floor_up = r_floor + FLOOR_W'(1);
  assign w_floor_dn = r_floor - FLOOR_W'(1);
  assign w_oh_cur   = N_FLOORS'(1) << r_floor;
  assign w_oh_up    = N_FLOORS'(1) << w_floor_up;
  assign w_oh_dn    = N_FLOORS'(1) << w_floor_dn;

  // Pending-call scan relative to the current floor and to the floor being arrived at.
  always_comb begin
    w_up_av    = 1'b0;
    w_dn_av    = 1'b0;
    w_above_up = 1'b0;
    w_below_dn = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (r_req[i]) begin
        if (FLOOR_W'(i) > r_floor)    w_up_av    = 1'b1;
        if (FLOOR_W'(i) < r_floor)    w_dn_av    = 1'b1;
        if (FLOOR_W'(i) > w_floor_up) w_above_up = 1'b1;
        if (FLOOR_W'(i) < w_floor_dn) w_below_dn = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_floor_nxt = r_floor;
    w_mcnt_nxt  = r_mcnt;
    w_dcnt_nxt  = r_dcnt;
    w_clr_mask  = '0;
    w_req_in    = req_set;
    case (r_state)
      S_IDLE: begin
        if (r_req[r_floor]) begin
          w_state_nxt = S_DOOR;
          w_clr_mask  = w_oh_cur;
          w_dcnt_nxt  = '0;
        end else if (r_dir == DIR_UP && w_up_av) begin
          w_state_nxt = S_MOVE_UP;
          w_mcnt_nxt  = '0;
        end else if (r_dir == DIR_DOWN && w_dn_av) begin
          w_state_nxt = S_MOVE_DOWN;
          w_mcnt_nxt  = '0;
        end else if (w_up_av) begin
          w_state_nxt = S_MOVE_UP;
          w_dir_nxt   = DIR_UP;
          w_mcnt_nxt  = '0;
        end else if (w_dn_av) begin
          w_state_nxt = S_MOVE_DOWN;
          w_dir_nxt   = DIR_DOWN;
          w_mcnt_nxt  = '0;
        end
      end
      S_MOVE_UP: begin
        if (r_mcnt == MOVE_LAST) begin
          w_floor_nxt = w_floor_up;
          w_mcnt_nxt  = '0;
          if (r_req[w_floor_up] || req_set[w_floor_up]) begin
            w_state_nxt = S_DOOR;
            w_clr_mask  = w_oh_up;
            w_dcnt_nxt  = '0;
          end else if (!w_above_up) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_mcnt_nxt = r_mcnt + CNT_W'(1);
        end
      end
      S_MOVE_DOWN: begin
        if (r_mcnt == MOVE_LAST) begin
          w_floor_nxt = w_floor_dn;
          w_mcnt_nxt  = '0;
          if (r_req[w_floor_dn] || req_set[w_floor_dn]) begin
            w_state_nxt = S_DOOR;
            w_clr_mask  = w_oh_dn;
            w_dcnt_nxt  = '0;
          end else if (!w_below_dn) begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_mcnt_nxt = r_mcnt + CNT_W'(1);
        end
      end
      S_DOOR: begin
        // A call at the open floor holds the door instead of queuing a new stop.
        w_req_in = req_set & ~w_oh_cur;
        if (req_set[r_floor]) begin
          w_dcnt_nxt = '0;
        end else if (r_dcnt == DOOR_LAST) begin
          w_state_nxt = S_IDLE;
          w_dcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + CNT_W'(1);
        end
      end
    endcase
  end

  assign w_req_nxt = (r_req | w_req_in) & ~w_clr_mask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= DIR_UP;
      r_floor <= '0;
      r_req   <= '0;
      r_mcnt  <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_floor <= w_floor_nxt;
      r_req   <= w_req_nxt;
      r_mcnt  <= w_mcnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  assign floor          = r_floor;
  assign floor_req      = r_req;
  assign moving_up      = (r_state == S_MOVE_UP);
  assign moving_down    = (r_state == S_MOVE_DOWN);
  assign door_open      = (r_state == S_DOOR);
  assign up_available   = w_up_av;
  assign down_available = w_dn_av;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed call sequences, door-stop scoreboard plus cycle-exact spot checks.
module tb_elevator_scan_ctrl;

  localparam int NF = 8;

  logic          clk;
  logic          rst_n;
  logic [NF-1:0] req_set;
  logic [2:0]    floor;
  logic [NF-1:0] floor_req;
  logic          moving_up, moving_down, door_open;
  logic          up_available, down_available;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int fl;
    int len;
  } door_t;

  door_t exp_q[$];

  elevator_scan_ctrl #(
    .N_FLOORS(8), .FLOOR_W(3), .MOVE_CYCLES(4), .DOOR_CYCLES(6)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_set       (req_set),
    .floor         (floor),
    .floor_req     (floor_req),
    .moving_up     (moving_up),
    .moving_down   (moving_down),
    .door_open     (door_open),
    .up_available  (up_available),
    .down_available(down_available)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_door(input int fl, input int len);
    door_t d;
    d.fl  = fl;
    d.len = len;
    exp_q.push_back(d);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NF-1:0] mask);
    @(negedge clk);
    req_set = mask;
    @(negedge clk);
    req_set = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic bit is_idle();
    return !moving_up && !moving_down && !door_open && (floor_req == '0);
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && !is_idle()) begin
      @(negedge clk);
      n++;
    end
    if (!is_idle()) begin
      checks++;
      errors++;
      $display("FAIL %s: not idle after %0d cycles, floor=%0d req=%0h", name, budget, floor, floor_req);
    end
  endtask

  task automatic wait_floor(input string name, input int f, input int budget);
    int n = 0;
    while (n < budget && int'(floor) != f) begin
      @(negedge clk);
      n++;
    end
    if (int'(floor) != f) begin
      checks++;
      errors++;
      $display("FAIL %s: floor %0d not reached in %0d cycles, at %0d", name, f, budget, floor);
    end
  endtask

  // Door-stop monitor: each completed door opening is matched against the expected stop list.
  bit    in_door = 1'b0;
  int    d_floor = 0;
  int    d_len   = 0;
  door_t d_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && door_open) begin
        if (!in_door) begin
          in_door = 1'b1;
          d_floor = int'(floor);
          d_len   = 0;
        end
        d_len++;
      end else if (in_door) begin
        in_door = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL door_unexpected: got stop at floor %0d len %0d, expected none", d_floor, d_len);
        end else begin
          d_exp = exp_q.pop_front();
          chk("door_floor", d_floor, d_exp.fl);
          chk("door_len", d_len, d_exp.len);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    req_set = '0;
    step(3);
    chk("rst_floor", int'(floor), 0);
    chk("rst_floor_req", int'(floor_req), 0);
    chk("rst_status", int'({moving_up, moving_down, door_open, up_available, down_available}), 0);
    rst_n = 1'b1;

    // Single call to floor 5 from floor 0: exact latency of latch, departure, arrival, door.
    expect_door(5, 6);
    req_set = 8'h20;
    @(negedge clk);
    req_set = '0;
    chk("t1_floor_req", int'(floor_req), 32'h20);
    chk("t1_up_avail", int'(up_available), 1);
    chk("t1_not_moving_yet", int'(moving_up), 0);
    step(1);
    chk("t2_moving_up", int'(moving_up), 1);
    step(19);
    chk("t21_floor4", int'(floor), 4);
    step(1);
    chk("t22_floor5", int'(floor), 5);
    chk("t22_door_open", int'(door_open), 1);
    chk("t22_floor_req_clr", int'(floor_req), 0);
    step(5);
    chk("door_last_cycle", int'(door_open), 1);
    step(1);
    chk("door_closed", int'(door_open), 0);
    chk("door_closed_idle", int'(is_idle()), 1);

    // Call at the current floor, then a repeat call while the door is open.
    do_reset();
    expect_door(0, 9);
    req_set = 8'h01;
    @(negedge clk);
    req_set = '0;
    chk("same_floor_latched", int'(floor_req), 1);
    @(negedge clk);
    chk("same_floor_door", int'(door_open), 1);
    chk("same_floor_req_clr", int'(floor_req), 0);
    step(2);
    req_set = 8'h01;
    @(negedge clk);
    req_set = '0;
    chk("door_hold_not_latched", int'(floor_req), 0);
    step(5);
    chk("door_hold_still_open", int'(door_open), 1);
    step(1);
    chk("door_hold_closed", int'(door_open), 0);

    // LOOK continuation: 2 -> 6 with a call at 1 arriving mid-trip.
    expect_door(2, 6);
    pulse(8'h04);
    wait_idle("look_to2", 300);
    expect_door(6, 6);
    expect_door(1, 6);
    pulse(8'h40);
    wait_floor("look_mid", 4, 300);
    pulse(8'h02);
    wait_idle("look_serve", 300);
    chk("look_end_floor", int'(floor), 1);
    expect_door(0, 6);
    expect_door(5, 6);
    req_set = 8'h21;
    @(negedge clk);
    req_set = '0;
    @(negedge clk);
    chk("look_dir_down", int'(moving_down), 1);
    chk("look_not_up", int'(moving_up), 0);
    wait_idle("look_after", 300);
    chk("look_after_floor", int'(floor), 5);

    // Simultaneous calls above and below at floor 3 with upward direction.
    do_reset();
    expect_door(3, 6);
    pulse(8'h08);
    wait_idle("simul_to3", 300);
    expect_door(5, 6);
    expect_door(1, 6);
    req_set = 8'h22;
    @(negedge clk);
    req_set = '0;
    @(negedge clk);
    chk("simul_up_first", int'(moving_up), 1);
    chk("simul_not_down", int'(moving_down), 0);
    wait_idle("simul_serve", 300);
    chk("simul_end_floor", int'(floor), 1);

    // Intermediate stop on the way to floor 7.
    do_reset();
    expect_door(4, 6);
    expect_door(7, 6);
    pulse(8'h80);
    wait_floor("mid_at3", 3, 300);
    pulse(8'h10);
    wait_idle("mid_serve", 300);
    chk("mid_end_floor", int'(floor), 7);

    // Reset while descending past floor 4 with calls pending.
    pulse(8'h05);
    wait_floor("rst_mid_at4", 4, 300);
    chk("pre_rst_moving_down", int'(moving_down), 1);
    chk("pre_rst_pending", int'(floor_req), 32'h05);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_floor", int'(floor), 0);
    chk("mid_rst_floor_req", int'(floor_req), 0);
    chk("mid_rst_status", int'({moving_up, moving_down, door_open, up_available, down_available}), 0);
    step(40);
    chk("post_rst_floor", int'(floor), 0);
    chk("post_rst_status", int'({moving_up, moving_down, door_open, floor_req}), 0);

    step(3);
    chk("door_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised successor to the combinational up/down-availability logic.
- Latches per-floor call requests and tracks the car floor itself.
- Runs a LOOK-style direction state machine with per-floor travel and door-dwell timers.
- Sits between the button/request capture logic and the motor/door drivers. Provides the availability flags internally plus registered car state.

Parameters:
- N_FLOORS, 8, number of served floors (≥2).
- FLOOR_W, 3, width of floor index; must satisfy 2^FLOOR_W ≥ N_FLOORS.
- MOVE_CYCLES, 4, clock cycles to travel one floor (≥1).
- DOOR_CYCLES, 6, clock cycles the door stays open (≥1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_set  input  N_FLOORS  one-cycle call pulses, bit i = floor i; multiple bits allowed per cycle.
- floor  output  FLOOR_W  current car floor (registered).
- floor_req  output  N_FLOORS  pending latched requests (registered).
- moving_up  output  1  high in MOVE_UP state.
- moving_down  output  1  high in MOVE_DOWN state.
- door_open  output  1  high in DOOR state.
- up_available  output  1  combinational: any floor_req bit at index > floor.
- down_available  output  1  combinational: any floor_req bit at index < floor.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge, any state, including mid-move or mid-door):
  - state=IDLE, floor=0, floor_req=0, dir=UP.
  - Move and door counters = 0.
  - All outputs 0 the following cycle.
- Request latch:
  - floor_req <= (floor_req | req_set) & ~clr_mask.
  - clr_mask is the one-hot bit of the floor at which DOOR is entered on that edge.
  - req_set appears in floor_req one cycle later.
  - Exception: in DOOR, a req_set bit equal to the current floor is not latched and instead restarts the door counter to 0.
  - req_set for the floor being cleared on the same edge is dropped (the door is opening there).
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR. dir is an internal register (UP/DOWN) holding the last travel direction.
- IDLE, priority order:
  1. floor_req[floor] → DOOR, clear that bit.
  2. dir=UP & up_available → MOVE_UP.
  3. dir=DOWN & down_available → MOVE_DOWN.
  4. up_available → MOVE_UP, dir=UP.
  5. down_available → MOVE_DOWN, dir=DOWN.
  6. Otherwise stay in IDLE.
- Entering a MOVE state sets the move counter to 0, and dir follows the state entered.
- MOVE_UP:
  - Move counter increments each cycle.
  - On the edge where counter = MOVE_CYCLES-1: floor <= floor+1, counter <= 0.
  - On that same edge, evaluated against the new floor f' = floor+1:
    - if floor_req[f'] or req_set[f'] → DOOR, clear bit f';
    - else if any request above f' → stay MOVE_UP;
    - else → IDLE.
- MOVE_DOWN: mirror of MOVE_UP with floor-1 and requests below.
- Floor never exceeds N_FLOORS-1 and never wraps below 0. Move states are only entered with a request strictly beyond the current floor.
- DOOR:
  - Door counter increments each cycle.
  - At counter = DOOR_CYCLES-1 → IDLE (direction re-evaluated there, which preserves LOOK continuation).
- Requests at other floors arriving during MOVE or DOOR are latched normally. They affect decisions from the next cycle.
- All counters are sized to hold max(MOVE_CYCLES, DOOR_CYCLES)-1. No arithmetic overflow is possible.

Test Plan:
- Reset then idle at floor 0; req_set=8'b0010_0000 pulse at cycle t → floor_req bit5 at t+1; moving_up at t+2; floor=5 and door_open=1 at t+22; floor_req=0; door_open low and IDLE after 6 cycles.
- At floor 0 idle, req_set bit0 → door_open at t+2 for exactly 6 cycles. A second bit0 pulse during DOOR extends door_open to 6 cycles after that pulse, and floor_req stays 0.
- LOOK continuation: car moving up from 2 toward 6, request at 1 arrives mid-trip → car serves 6 first, then descends to 1. dir remains DOWN afterward.
- Intermediate stop: moving up toward 7, req_set bit4 pulsed while floor=3 mid-travel → car opens at 4, then continues to 7.
- Simultaneous requests above and below with dir=UP at floor 3 (bits 1 and 5 set same cycle) → MOVE_UP chosen first.
- Assert rst_n=0 for one cycle while floor=4 in MOVE_DOWN with pending bits → next cycle floor=0, floor_req=0, all status outputs 0, state IDLE; pre-reset requests are not served.
